// File: rtl/clarvi_regfile_writeback_pkg.sv
// Shared types for the sliced register-file write-back path.
package clarvi_regfile_writeback_pkg;

  localparam int NUM_REGS = 32;
  localparam int PART_W   = 16;

  typedef logic [4:0] register_t;
  typedef logic [1:0] part_t;

  typedef struct packed {
    logic [31:0] pc;
    register_t   rd;
    logic        enable_wb;
    part_t       instr_part;
    logic        is32_bit_op;
  } instr_t;

  function automatic logic [3:0] part_onehot(part_t p);
    return 4'b0001 << p;
  endfunction

endpackage

// File: rtl/clarvi_regfile_writeback_if.sv
// WB-stage / decode-side bundle of the register-file write-back block.
interface clarvi_regfile_writeback_if
  import clarvi_regfile_writeback_pkg::*;
#(parameter int CNT_W = 64);

  logic              wb_invalid;
  instr_t            ma_wb_instr;
  logic [PART_W-1:0] wb_value;
  register_t         rs1_addr;
  register_t         rs2_addr;
  part_t             rd_part;
  logic [PART_W-1:0] rs1_fetched;
  logic [PART_W-1:0] rs2_fetched;
  logic [PART_W-1:0] wb_forward_value;
  logic              instr_retired;
  logic [CNT_W-1:0]  retired_count;

  modport master (
    output wb_invalid, ma_wb_instr, wb_value, rs1_addr, rs2_addr, rd_part,
    input  rs1_fetched, rs2_fetched, wb_forward_value, instr_retired, retired_count
  );

  modport slave (
    input  wb_invalid, ma_wb_instr, wb_value, rs1_addr, rs2_addr, rd_part,
    output rs1_fetched, rs2_fetched, wb_forward_value, instr_retired, retired_count
  );

endinterface

// File: rtl/clarvi_regfile_writeback_bank.sv
// One 16-bit slice of the register file: single write port, two async read ports, x0 reads zero.
module clarvi_regfile_bank
  import clarvi_regfile_writeback_pkg::*;
#(
  parameter int NREGS = NUM_REGS,
  parameter int W     = PART_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         we_i,
  input  register_t    waddr_i,
  input  logic [W-1:0] wdata_i,
  input  register_t    raddr1_i,
  input  register_t    raddr2_i,
  output logic [W-1:0] rdata1_o,
  output logic [W-1:0] rdata2_o
);

  logic [W-1:0] regs_q [NREGS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/clarvi_regfile_writeback.sv
// Register-file write end: slice writes, 32-bit-op sign substitution, slice tracking and retire count.
// Optional slice-order checker enabled by CLARVI_WB_ORDER_CHECK_EN.
module clarvi_regfile_writeback
  import clarvi_regfile_writeback_pkg::*;
#(parameter int CNT_W = 64) (
  input  logic clock,
  input  logic reset,
  clarvi_regfile_writeback_if.slave wb
`ifdef CLARVI_WB_ORDER_CHECK_EN
  , output logic part_order_error
`endif
);

  instr_t            instr;
  logic              wb_valid;
  logic [3:0]        part_oh;
  logic [PART_W-1:0] write_val;
  logic              write_en;
  logic [PART_W-1:0] rs1_part [4];
  logic [PART_W-1:0] rs2_part [4];

  logic              sign_latch_q, sign_latch_d;
  logic [3:0]        parts_seen_q, parts_seen_d;
  logic [31:0]       cur_pc_q, cur_pc_d;
  logic [CNT_W-1:0]  retired_count_q, retired_count_d;
  logic              new_instr;
  logic [3:0]        mask_upd;
  logic              retire;

  assign instr    = wb.ma_wb_instr;
  assign wb_valid = !wb.wb_invalid;
  assign part_oh  = part_onehot(instr.instr_part);
  assign write_en = wb_valid && instr.enable_wb && (instr.rd != '0);

  // Upper slices of a 32-bit op carry the sign of slice 1, captured earlier.
  assign write_val = (instr.is32_bit_op && instr.instr_part[1]) ? {PART_W{sign_latch_q}}
                                                                : wb.wb_value;

  for (genvar p = 0; p < 4; p++) begin : g_bank
    clarvi_regfile_bank #(.NREGS(NUM_REGS), .W(PART_W)) u_bank (
      .clock    (clock),
      .reset    (reset),
      .we_i     (write_en && part_oh[p]),
      .waddr_i  (instr.rd),
      .wdata_i  (write_val),
      .raddr1_i (wb.rs1_addr),
      .raddr2_i (wb.rs2_addr),
      .rdata1_o (rs1_part[p]),
      .rdata2_o (rs2_part[p])
    );
  end

  always_comb begin
    sign_latch_d    = sign_latch_q;
    parts_seen_d    = parts_seen_q;
    cur_pc_d        = cur_pc_q;
    retired_count_d = retired_count_q;
    new_instr       = 1'b0;
    mask_upd        = parts_seen_q;
    retire          = 1'b0;
    if (wb_valid) begin
      if (instr.is32_bit_op && (instr.instr_part == 2'd1)) sign_latch_d = wb.wb_value[PART_W-1];
      new_instr = (instr.pc != cur_pc_q) || (parts_seen_q == 4'b0000);
      mask_upd  = new_instr ? part_oh : (parts_seen_q | part_oh);
      if (new_instr) cur_pc_d = instr.pc;
      retire = (mask_upd == 4'b1111);
      if (retire) begin
        parts_seen_d    = 4'b0000;
        retired_count_d = retired_count_q + CNT_W'(1);
      end else begin
        parts_seen_d = mask_upd;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sign_latch_q    <= 1'b0;
      parts_seen_q    <= 4'b0000;
      cur_pc_q        <= '0;
      retired_count_q <= '0;
    end else begin
      sign_latch_q    <= sign_latch_d;
      parts_seen_q    <= parts_seen_d;
      cur_pc_q        <= cur_pc_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign wb.rs1_fetched      = rs1_part[wb.rd_part];
  assign wb.rs2_fetched      = rs2_part[wb.rd_part];
  assign wb.wb_forward_value = write_val;
  assign wb.instr_retired    = retire && !reset;
  assign wb.retired_count    = retired_count_q;

`ifdef CLARVI_WB_ORDER_CHECK_EN
  logic order_err_q, order_err_d;
  logic order_viol;

  always_comb begin
    order_viol = 1'b0;
    if (wb_valid) begin
      order_viol = (!new_instr && ((parts_seen_q & part_oh) != 4'b0000))
                || (instr.is32_bit_op && instr.instr_part[1] && !mask_upd[1])
                || ((instr.pc != cur_pc_q) && (parts_seen_q != 4'b0000));
    end
    order_err_d = order_err_q || order_viol;
  end

  always_ff @(posedge clock) begin
    if (reset) order_err_q <= 1'b0;
    else       order_err_q <= order_err_d;
  end

  assign part_order_error = order_err_q;
`endif

endmodule

// File: tb/tb_clarvi_regfile_writeback.sv
// Directed bench for clarvi_regfile_writeback; order-checker cases build with CLARVI_WB_ORDER_CHECK_EN.
module tb_clarvi_regfile_writeback;
  import clarvi_regfile_writeback_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total  = 0;
  logic [63:0] exp_count = '0;

  always #5 clock = ~clock;

  clarvi_regfile_writeback_if #(.CNT_W(64)) bus ();

`ifdef CLARVI_WB_ORDER_CHECK_EN
  logic part_order_error;
`endif

  clarvi_regfile_writeback #(.CNT_W(64)) dut (
    .clock (clock),
    .reset (reset),
    .wb    (bus.slave)
`ifdef CLARVI_WB_ORDER_CHECK_EN
    , .part_order_error (part_order_error)
`endif
  );

  // All tasks start and end 1 time unit after a rising edge.
  task automatic slice(input register_t rd, input logic en, input part_t part, input logic is32,
                       input logic [31:0] pc, input logic [15:0] val,
                       output logic ret, output logic [15:0] fwd, output logic [15:0] r1);
    instr_t ins;
    ins.pc = pc; ins.rd = rd; ins.enable_wb = en; ins.instr_part = part; ins.is32_bit_op = is32;
    bus.ma_wb_instr = ins;
    bus.wb_value    = val;
    bus.wb_invalid  = 1'b0;
    @(negedge clock);
    ret = bus.instr_retired;
    fwd = bus.wb_forward_value;
    r1  = bus.rs1_fetched;
    @(posedge clock); #1;
    bus.wb_invalid = 1'b1;
  endtask

  task automatic read_reg(input register_t addr, input part_t part, output logic [15:0] v);
    bus.rs1_addr = addr;
    bus.rs2_addr = addr;
    bus.rd_part  = part;
    @(negedge clock);
    v = bus.rs2_fetched;
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    instr_t ins;
    logic [15:0] v;
    ins.pc = 32'h4; ins.rd = 5'd7; ins.enable_wb = 1'b1; ins.instr_part = 2'd0; ins.is32_bit_op = 1'b0;
    bus.ma_wb_instr = ins; bus.wb_value = 16'hABCD; bus.wb_invalid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    total++;
    if (bus.instr_retired !== 1'b0) $display("FAIL reset_pulse got %b want 0", bus.instr_retired);
    else passed++;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0; bus.wb_invalid = 1'b1;
    read_reg(5'd7, 2'd0, v);
    total++;
    if (v !== 16'h0000) $display("FAIL reset_overrides_write got %h want 0000", v);
    else passed++;
    total++;
    if (bus.retired_count !== 64'd0) $display("FAIL reset_count got %0d want 0", bus.retired_count);
    else passed++;
  endtask

  task automatic test_add();
    logic [15:0] vals [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [3:0] rets; logic [15:0] f, r, v;
    for (int i = 0; i < 4; i++) slice(5'd5, 1'b1, part_t'(i), 1'b0, 32'h100, vals[i], rets[i], f, r);
    exp_count++;
    total++;
    if (rets !== 4'b1000) $display("FAIL add_retire_pulse got %b want 1000", rets);
    else passed++;
    total++;
    if (bus.retired_count !== exp_count) $display("FAIL add_count got %0d want %0d", bus.retired_count, exp_count);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      read_reg(5'd5, part_t'(i), v);
      total++;
      if (v !== vals[i]) $display("FAIL add_x5_part%0d got %h want %h", i, v, vals[i]);
      else passed++;
    end
  endtask

  task automatic test_addw();
    logic [15:0] exp [4] = '{16'h0001, 16'h8000, 16'hFFFF, 16'hFFFF};
    logic ret; logic [15:0] f, r, v;
    slice(5'd6, 1'b1, 2'd0, 1'b1, 32'h104, 16'h0001, ret, f, r);
    slice(5'd6, 1'b1, 2'd1, 1'b1, 32'h104, 16'h8000, ret, f, r);
    slice(5'd6, 1'b1, 2'd2, 1'b1, 32'h104, 16'h1234, ret, f, r);
    total++;
    if (f !== 16'hFFFF) $display("FAIL addw_forward_sign got %h want FFFF", f);
    else passed++;
    slice(5'd6, 1'b1, 2'd3, 1'b1, 32'h104, 16'h5678, ret, f, r);
    exp_count++;
    for (int i = 0; i < 4; i++) begin
      read_reg(5'd6, part_t'(i), v);
      total++;
      if (v !== exp[i]) $display("FAIL addw_x6_part%0d got %h want %h", i, v, exp[i]);
      else passed++;
    end
  endtask

  task automatic test_srlw();
    part_t order [4] = '{2'd1, 2'd0, 2'd3, 2'd2};
    logic [15:0] vals [4] = '{16'h7FFF, 16'h0002, 16'hAAAA, 16'hAAAA};
    logic [3:0] rets; logic [15:0] f, r, v;
    for (int i = 0; i < 4; i++) slice(5'd7, 1'b1, order[i], 1'b1, 32'h108, vals[i], rets[i], f, r);
    exp_count++;
    total++;
    if (bus.retired_count !== exp_count) $display("FAIL srlw_count got %0d want %0d", bus.retired_count, exp_count);
    else passed++;
    read_reg(5'd7, 2'd2, v);
    total++;
    if (v !== 16'h0000) $display("FAIL srlw_x7_part2 got %h want 0000", v);
    else passed++;
    read_reg(5'd7, 2'd3, v);
    total++;
    if (v !== 16'h0000) $display("FAIL srlw_x7_part3 got %h want 0000", v);
    else passed++;
`ifdef CLARVI_WB_ORDER_CHECK_EN
    total++;
    if (part_order_error !== 1'b0) $display("FAIL srlw_no_order_err got %b want 0", part_order_error);
    else passed++;
`endif
  endtask

  task automatic test_x0();
    logic ret; logic [15:0] f, r, v;
    bus.rs1_addr = 5'd0; bus.rd_part = 2'd0;
    for (int i = 0; i < 4; i++) slice(5'd0, 1'b1, part_t'(i), 1'b0, 32'h10C, 16'hFFFF, ret, f, r);
    exp_count++;
    total++;
    if (bus.retired_count !== exp_count) $display("FAIL x0_count got %0d want %0d", bus.retired_count, exp_count);
    else passed++;
    for (int i = 0; i < 4; i += 3) begin
      read_reg(5'd0, part_t'(i), v);
      total++;
      if (v !== 16'h0000) $display("FAIL x0_part%0d got %h want 0000", i, v);
      else passed++;
    end
  endtask

  task automatic test_forward();
    logic ret; logic [15:0] f, r, v;
    bus.rs1_addr = 5'd5; bus.rd_part = 2'd0;
    slice(5'd5, 1'b1, 2'd0, 1'b0, 32'h110, 16'h9999, ret, f, r);
    total++;
    if (r !== 16'h1111) $display("FAIL rdw_old_value got %h want 1111", r);
    else passed++;
    total++;
    if (f !== 16'h9999) $display("FAIL rdw_forward got %h want 9999", f);
    else passed++;
    for (int i = 1; i < 4; i++) slice(5'd5, 1'b1, part_t'(i), 1'b0, 32'h110, 16'h0000, ret, f, r);
    exp_count++;
    read_reg(5'd5, 2'd0, v);
    total++;
    if (v !== 16'h9999) $display("FAIL rdw_after got %h want 9999", v);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] rets; logic [15:0] f, r;
    for (int i = 0; i < 4; i++) slice(5'd10, 1'b0, part_t'(i), 1'b0, 32'h300, 16'h0, rets[i], f, r);
    for (int i = 0; i < 4; i++) slice(5'd11, 1'b1, part_t'(i), 1'b0, 32'h304, 16'h0, rets[4+i], f, r);
    exp_count += 2;
    total++;
    if (rets !== 8'b1000_1000) $display("FAIL b2b_pulses got %b want 10001000", rets);
    else passed++;
    total++;
    if (bus.retired_count !== exp_count) $display("FAIL b2b_count got %0d want %0d", bus.retired_count, exp_count);
    else passed++;
  endtask

  task automatic test_flush();
    logic [5:0] rets; logic [15:0] f, r;
    slice(5'd9, 1'b1, 2'd2, 1'b0, 32'h200, 16'h0, rets[0], f, r);
    slice(5'd9, 1'b1, 2'd3, 1'b0, 32'h200, 16'h0, rets[1], f, r);
    for (int i = 0; i < 4; i++) slice(5'd9, 1'b1, part_t'(i), 1'b0, 32'h204, 16'h0, rets[2+i], f, r);
    exp_count++;
    total++;
    if (rets !== 6'b100000) $display("FAIL flush_pulses got %b want 100000", rets);
    else passed++;
    total++;
    if (bus.retired_count !== exp_count) $display("FAIL flush_count got %0d want %0d", bus.retired_count, exp_count);
    else passed++;
`ifdef CLARVI_WB_ORDER_CHECK_EN
    total++;
    if (part_order_error !== 1'b1) $display("FAIL flush_order_err got %b want 1", part_order_error);
    else passed++;
`endif
  endtask

  task automatic test_mid_reset();
    logic [1:0] rets; logic ret; logic [15:0] f, r, v;
    slice(5'd12, 1'b1, 2'd0, 1'b0, 32'h400, 16'h5555, ret, f, r);
    slice(5'd12, 1'b1, 2'd1, 1'b0, 32'h400, 16'h5555, ret, f, r);
    do_reset();
    exp_count = '0;
    total++;
    if (bus.retired_count !== 64'd0) $display("FAIL midrst_count got %0d want 0", bus.retired_count);
    else passed++;
    slice(5'd12, 1'b1, 2'd2, 1'b0, 32'h400, 16'h5555, rets[0], f, r);
    slice(5'd12, 1'b1, 2'd3, 1'b0, 32'h400, 16'h5555, rets[1], f, r);
    total++;
    if (rets !== 2'b00 || bus.retired_count !== 64'd0)
      $display("FAIL midrst_no_retire got pulses %b count %0d want 00 count 0", rets, bus.retired_count);
    else passed++;
    read_reg(5'd12, 2'd0, v);
    total++;
    if (v !== 16'h0000) $display("FAIL midrst_x12_cleared got %h want 0000", v);
    else passed++;
`ifdef CLARVI_WB_ORDER_CHECK_EN
    total++;
    if (part_order_error !== 1'b0) $display("FAIL midrst_err_cleared got %b want 0", part_order_error);
    else passed++;
`endif
  endtask

`ifdef CLARVI_WB_ORDER_CHECK_EN
  task automatic test_order_check();
    logic ret; logic [15:0] f, r, v;
    do_reset();
    slice(5'd13, 1'b1, 2'd0, 1'b0, 32'h500, 16'h1, ret, f, r);
    total++;
    if (part_order_error !== 1'b0) $display("FAIL order_first_ok got %b want 0", part_order_error);
    else passed++;
    slice(5'd13, 1'b1, 2'd0, 1'b0, 32'h500, 16'h1, ret, f, r);
    read_reg(5'd13, 2'd0, v);
    read_reg(5'd13, 2'd0, v);
    total++;
    if (part_order_error !== 1'b1) $display("FAIL order_repeat_held got %b want 1", part_order_error);
    else passed++;
    do_reset();
    total++;
    if (part_order_error !== 1'b0) $display("FAIL order_reset_clears got %b want 0", part_order_error);
    else passed++;
    slice(5'd13, 1'b1, 2'd2, 1'b1, 32'h504, 16'h1, ret, f, r);
    total++;
    if (part_order_error !== 1'b1) $display("FAIL order_sign_before_s1 got %b want 1", part_order_error);
    else passed++;
    do_reset();
  endtask
`endif

  initial begin
    bus.wb_invalid  = 1'b1;
    bus.ma_wb_instr = '0;
    bus.wb_value    = '0;
    bus.rs1_addr    = '0;
    bus.rs2_addr    = '0;
    bus.rd_part     = '0;
    #1;
    test_reset();
    test_add();
    test_addw();
    test_srlw();
    test_x0();
    test_forward();
    test_back_to_back();
    test_flush();
    test_mid_reset();
`ifdef CLARVI_WB_ORDER_CHECK_EN
    test_order_check();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
